rng_share_arbiter: RTL
======================

# rng_share_arbiter

Round-robin controller that shares one free-running xorwow generator among `NUM_REQ` requesters and sequences its reseed. Each granted request receives one distinct 32-bit draw. A reseed drives the generator's load strobe and then discards `WARMUP` outputs before service resumes. It sits between the xorwow instance and its consumers; the top level ties the generator's `rst_n` to `~rst`, so both leave reset on the same edge.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `WARMUP`, default 8: generator outputs discarded after a reseed, ≥0.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request, held until accepted.
- `req_ready` out NUM_REQ: one-hot grant, combinational; accept when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out NUM_REQ: one-hot, registered, one-cycle pulse for the granted requester.
- `rsp_data` out 32: draw for the `rsp_valid` requester; holds its last value otherwise.
- `seed_valid` in 1: reseed request, held until accepted.
- `seed` in 32: new x seed, sampled on accept.
- `seed_ready` out 1: combinational; high only in RUN.
- `busy` out 1: high in RESEED or WARM.
- `rng_rnd` in 32: generator output, which advances every clock.
- `rng_seed` out 32: registered; captured seed to the generator.
- `rng_re_seed` out 1: registered decode; high exactly during RESEED.

## Operation
- States:
  - RUN: grants allowed.
  - RESEED: one cycle; `rng_re_seed` = 1.
  - WARM: `WARMUP` cycles; generator outputs discarded.
- Transitions:
  - RUN → RESEED on a `seed_valid` accept; `rng_seed` ← `seed`.
  - RESEED → WARM if `WARMUP` > 0, else → RUN.
  - WARM → RUN when down-counter `cnt` (width clog2(WARMUP+1)) reaches 1. `cnt` loads `WARMUP` on entry and decrements each WARM cycle.
- Seed priority: if `seed_valid` is high in RUN, `req_ready` = 0 that cycle. The seed is accepted and no grant is issued.
- Arbitration in RUN with no seed pending:
  - Grant the first `i` with `req_valid[i]`, scanning `ptr`, `ptr`+1, … mod `NUM_REQ`.
  - At most one grant per cycle.
  - On a grant, `ptr` ← (i+1) mod `NUM_REQ`; otherwise `ptr` holds.
- Response: on the grant edge, `rsp_data` ← `rng_rnd` and `rsp_valid` ← grant one-hot. Draws to back-to-back grants are distinct successive generator outputs.
- Non-RUN states: `req_ready` = 0 and `seed_ready` = 0. A `seed_valid` in RESEED or WARM waits; it is not dropped or queued twice.
- `ptr` is unaffected by a reseed.
- Generator semantics: a reseed sets x = seed and y, z, w, v, d to defaults. The output is d+v, so the first post-reseed output is 12398562 regardless of seed.

## Timing
- Reset, `rst` high at an edge:
  - state = RUN, `ptr` = 0, `cnt` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rng_seed` = 0, `rng_re_seed` = 0, `busy` = 0.
- While `rst` is high, `req_ready` = 0 and `seed_ready` = 0 (gated).
- First cycle after release: `rng_rnd` = 12398562 (= 6615241 + 5783321).
- Grant-to-response latency: grant in cycle t gives `rsp_valid` / `rsp_data` in t+1.
- Reseed accepted in cycle t:
  - t+1: `rng_re_seed` = 1, `busy` = 1.
  - Generator loads at the end of t+1.
  - t+2 … t+1+WARMUP: WARM.
  - t+2+WARMUP: RUN; the first grantable `rng_rnd` is post-reseed step `WARMUP`.
  - `busy` is high for exactly WARMUP+1 cycles.
- Reset mid-RESEED or mid-WARM: an abort. Next cycle is RUN with all outputs at reset values, and the generator is at defaults.
- Pointer wrap: after granting `NUM_REQ`-1, `ptr` = 0.

## Test plan
- Reset, then `req_valid` = 0001 in the first free cycle → `req_ready` = 0001 that cycle. Next cycle `rsp_valid` = 0001 and `rsp_data` = 12398562.
- `req_valid` = 1111 for 8 cycles → grants 0,1,2,3,0,1,2,3. The `rsp_data` stream equals golden-model outputs 0..7, and no `rsp_valid` has more than one bit set.
- Grant to 2 (`ptr` = 3), then `req_valid` = 0011 → grant 0 (wrap past 3). Next `req_valid` = 0011 → grant 1.
- `seed_valid` = 1, `seed` = 1, with `req_valid` = 1111 in RUN, `WARMUP` = 8 →
  - no grant that cycle;
  - next cycle `rng_re_seed` = 1 and `rng_seed` = 1;
  - `busy` high for 9 cycles, `req_ready` = 0 throughout;
  - grants then resume at the unchanged `ptr`, and the first `rsp_data` = golden(seed=1, step 8).
- `WARMUP` = 0, reseed with `seed` = 0xDEADBEEF, `req_valid[0]` held → `busy` for 1 cycle. The next grant's `rsp_data` = 12398562.
- Assert `rst` during WARM cycle 3 → next cycle `busy` = 0, `rsp_valid` = 0, `ptr` = 0. After release, the first draw = 12398562. A `seed_valid` held across the reset is accepted only in RUN, after release.

Source files
------------

// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter sharing one free-running xorwow generator among NUM_REQ requesters,
// with a reseed sequence that strobes the generator load and then discards WARMUP outputs.
module rng_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [31:0]        rsp_data,
  input  logic               seed_valid,
  input  logic [31:0]        seed,
  output logic               seed_ready,
  output logic               busy,
  input  logic [31:0]        rng_rnd,
  output logic [31:0]        rng_seed,
  output logic               rng_re_seed
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = PW + 1;
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic [1:0] {RUN, RESEED, WARM} state_t;

  state_t             state_q;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [31:0]        rng_seed_q;
  logic               rng_re_seed_q;
  logic               busy_q;
  logic               run;
  logic [SW-1:0]      sum;
  logic               found;

  // Grants are gated off during reset and whenever a reseed request is pending.
  assign run        = (state_q == RUN) && !rst;
  assign seed_ready = run;
  assign req_ready  = (run && !seed_valid) ? grant : '0;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!found && req_valid[sum[PW-1:0]]) begin
        found                = 1'b1;
        grant[sum[PW-1:0]]   = 1'b1;
        ptr_d = (sum[PW-1:0] == PW'(NUM_REQ - 1)) ? '0 : sum[PW-1:0] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ptr_q         <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rng_seed_q    <= '0;
      rng_re_seed_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rsp_valid_q <= req_ready;
      if (|req_ready) begin
        rsp_data_q <= rng_rnd;
        ptr_q      <= ptr_d;
      end
      case (state_q)
        RUN: begin
          if (seed_valid) begin
            state_q       <= RESEED;
            rng_seed_q    <= seed;
            rng_re_seed_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        RESEED: begin
          rng_re_seed_q <= 1'b0;
          if (WARMUP > 0) begin
            state_q <= WARM;
            cnt_q   <= CW'(WARMUP);
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        WARM: begin
          // The generator loaded at the end of RESEED; each WARM cycle burns one output.
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rng_seed    = rng_seed_q;
  assign rng_re_seed = rng_re_seed_q;
  assign busy        = busy_q;

endmodule
